sqrt_inv: RTL
=============

# sqrt_inv

Iterative inverse of the integer square-root unit: given a root and remainder, it reconstructs the radicand `result = root*root + rem` with one shift-add step per cycle. It shares the start/busy/valid handshake of the square-root unit, so it can be chained directly after it. Uses:
- round-trip checking of square-root results in hardware and benches;
- regenerating a radicand from stored (root, rem) pairs.

## Interface
Parameters:
- `WIDTH`, 8: width of `root` and `rem` operands; must be even and ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  load operands and begin a calculation.
- `root`  in  `WIDTH`  root operand, unsigned; sampled only on a `start` edge.
- `rem`  in  `WIDTH`  remainder operand, unsigned; sampled only on a `start` edge.
- `busy`  out  1  calculation in progress.
- `valid`  out  1  `result` and `ovf` are valid.
- `result`  out  `2*WIDTH`  `root*root + rem`.
- `ovf`  out  1  `result` ≥ 2^`WIDTH`, i.e. not representable as a `WIDTH`-bit radicand.

## Operation
- Internal state:
  - multiplicand register `mc`, `2*WIDTH` bits;
  - multiplier register `mp`, `WIDTH` bits;
  - accumulator `acc`, `2*WIDTH` bits;
  - iteration counter `i`, ceil(log2(`WIDTH`)) bits.
- States: IDLE (`busy`=0) and RUN (`busy`=1); there is no separate DONE state.
- `start` on any edge, including while busy, does the following:
  - `mc` ← zero-extended `root`; `mp` ← `root`; `acc` ← zero-extended `rem`; `i` ← 0;
  - `busy` ← 1; `valid` ← 0.
- When starting while busy, the in-flight calculation is abandoned and its result is never presented.
- RUN step, each edge with `busy`=1 and `start`=0:
  - if `mp[0]`, `acc_next` = `acc + mc`, else `acc_next` = `acc`;
  - `mc` ← `mc << 1`; `mp` ← `mp >> 1`.
- Completion, on the step where `i` = `WIDTH-1`:
  - `result` ← `acc_next`;
  - `ovf` ← OR of `acc_next[2*WIDTH-1:WIDTH]`;
  - `busy` ← 0; `valid` ← 1.
- All other RUN steps increment `i`.
- Width rules:
  - the maximum is (2^W−1)^2 + (2^W−1) = 2^(2W) − 2^W, so `acc` never overflows `2*WIDTH` bits;
  - no carry-out needs to be handled.
- Fixed iteration count: there is no early exit when `mp` reaches 0.
- `result`, `ovf` and `valid` hold their values until the next `start`.
- In IDLE with no `start`, nothing changes.
- Operand inputs are ignored on every edge except a `start` edge.

## Timing
- Reset (`rst_n`=0, asynchronous): `busy`=0, `valid`=0, `result`=0, `ovf`=0; internal registers and counter cleared.
- Reset mid-calculation aborts it. After release the block is in IDLE and `valid` stays 0 until a new calculation completes.
- Latency:
  - `start` is sampled at edge E; `busy`=1 from E;
  - `valid`=1 and `result` updated at edge E+`WIDTH`;
  - `busy`=0 at the same edge E+`WIDTH`.
- Throughput: a new `start` is accepted at edge E+`WIDTH` or later with no dead cycle. A `start` at E+`WIDTH` wins: `valid` goes to 0 and `busy` stays 1.
- `start` held high for multiple cycles reloads every cycle; the calculation begins on the last `start` edge.
- `valid` is a level, not a pulse.

## Test plan
- Reset and first calculation:
  - release reset, then idle for 5 cycles → `busy`=0, `valid`=0, `result`=0, `ovf`=0;
  - with `WIDTH`=8, `start` with `root`=13, `rem`=7 → `result`=176, `ovf`=0;
  - `valid` rises exactly 8 edges after the `start` edge, and `busy` is high for exactly those 8 cycles.
- Boundary values, `WIDTH`=8:
  - `root`=0, `rem`=0 → 0, `ovf`=0;
  - `root`=15, `rem`=30 → 255, `ovf`=0;
  - `root`=16, `rem`=0 → 256, `ovf`=1;
  - `root`=255, `rem`=255 → 65280, `ovf`=1.
- Restart while busy: start (13, 7), then after 3 cycles start (20, 1) → only 401 is ever presented, with `valid` 8 edges after the second `start`.
- Back-to-back: assert `start` (9, 0) on the same edge that completes the previous calculation → `valid` drops, and 81 is presented 8 edges later with no lost cycle.
- Asynchronous reset mid-run: assert `rst_n`=0 between edges at iteration 4 → outputs go to 0 immediately, without waiting for a clock edge. After release, `valid` stays 0 until a new `start` completes.
- Round trip with the square-root unit, `WIDTH`=8: for every radicand 0..255, feed its (root, rem) in → `result` equals the radicand and `ovf`=0 for all 256 cases.

Source files
------------

// File: rtl/sqrt_inv.sv
// sqrt_inv: iterative reconstruction of a radicand from an integer square root.
// Computes result = root*root + rem with one shift-add step per cycle, using the
// same start/busy/valid handshake as the square-root unit so the two chain directly.
module sqrt_inv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   root,
  input  logic [WIDTH-1:0]   rem,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]     mp_q, mp_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        i_q, i_d;
  logic                 valid_d;
  logic [2*WIDTH-1:0]   result_d;
  logic                 ovf_d;
  logic [2*WIDTH-1:0]   acc_step;

  // Anything at or above 2^WIDTH cannot be a WIDTH-bit radicand.
  function automatic logic ovf_of(input logic [2*WIDTH-1:0] v);
    return |v[2*WIDTH-1:WIDTH];
  endfunction

  assign busy = (state_q == RUN);

  // State and datapath registers; reset clears everything so no stale result survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mc_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      valid   <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      valid   <= valid_d;
      result  <= result_d;
      ovf     <= ovf_d;
    end
  end

  // Next-state and shift-add step; start always wins, abandoning any in-flight run.
  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    acc_d    = acc_q;
    i_d      = i_q;
    valid_d  = valid;
    result_d = result;
    ovf_d    = ovf;
    acc_step = mp_q[0] ? (acc_q + mc_q) : acc_q;

    if (start) begin
      mc_d    = {{WIDTH{1'b0}}, root};
      mp_d    = root;
      acc_d   = {{WIDTH{1'b0}}, rem};
      i_d     = '0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      acc_d = acc_step;
      // Fixed iteration count: no early exit even once the multiplier is exhausted.
      if (i_q == LAST) begin
        result_d = acc_step;
        ovf_d    = ovf_of(acc_step);
        valid_d  = 1'b1;
        state_d  = IDLE;
      end else begin
        i_d = i_q + CW'(1);
      end
    end
  end

endmodule
